// File: rtl/clock_time_setter_pkg.sv
// rtl/clock_time_setter_pkg.sv - shared limits, state encoding and field codes for time setting
package clock_time_setter_pkg;

    localparam logic [5:0] HOURS_MAX   = 6'd23;
    localparam logic [5:0] MINUTES_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } set_state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;

    // Modular +1/-1 over 0..max_value.
    function automatic logic [5:0] wrap_step(input logic [5:0] value,
                                             input logic [5:0] max_value,
                                             input logic       up);
        if (up)
            return (value >= max_value) ? 6'd0 : value + 6'd1;
        else
            return (value == 6'd0) ? max_value : value - 6'd1;
    endfunction

endpackage

// File: rtl/clock_time_setter_if.sv
// rtl/clock_time_setter_if.sv - bundle between the time setter and the clock core
interface clock_time_setter_if;
    import clock_time_setter_pkg::*;

    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [4:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       load;
    logic       setting;
    logic [1:0] field;

    modport master (
        input  cur_hours, cur_minutes,
        output set_hours, set_minutes, set_seconds, load, setting, field
    );

    modport slave (
        output cur_hours, cur_minutes,
        input  set_hours, set_minutes, set_seconds, load, setting, field
    );

endinterface

// File: rtl/clock_time_setter_button_debounce.sv
// rtl/clock_time_setter_button_debounce.sv - 2-FF synchroniser, stability debounce and press pulse
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clkin,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] count;

    // level only moves after the synced input has differed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            count  <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync_b;
                count <= '0;
                press <= sync_b;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_time_setter.sv
// rtl/clock_time_setter.sv - button-driven hours/minutes editor that writes back to the clock core
module clock_time_setter
    import clock_time_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_S       = 30
) (
    input  logic                       clkin,
    input  logic                       reset,
    input  logic                       btn_mode_raw,
    input  logic                       btn_inc_raw,
    input  logic                       btn_dec_raw,
    input  logic                       tick_1hz,
    clock_time_setter_if.master        core
);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_S - 1);

    set_state_t    state, state_next;
    logic [4:0]    hours_q, hours_next;
    logic [5:0]    minutes_q, minutes_next;
    logic [TW-1:0] idle_count, idle_next;
    logic          press_mode, press_inc, press_dec;
    logic          any_press, step_en, in_set;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clkin(clkin), .reset(reset), .raw(btn_mode_raw), .press(press_mode));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clkin(clkin), .reset(reset), .raw(btn_inc_raw), .press(press_inc));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clkin(clkin), .reset(reset), .raw(btn_dec_raw), .press(press_dec));

    assign any_press = press_mode | press_inc | press_dec;
    assign step_en   = press_inc ^ press_dec;
    assign in_set    = (state == ST_SET_HOUR) || (state == ST_SET_MIN);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state      <= ST_RUN;
            hours_q    <= '0;
            minutes_q  <= '0;
            idle_count <= '0;
        end else begin
            state      <= state_next;
            hours_q    <= hours_next;
            minutes_q  <= minutes_next;
            idle_count <= idle_next;
        end
    end

    always_comb begin
        state_next   = state;
        hours_next   = hours_q;
        minutes_next = minutes_q;
        idle_next    = '0;
        case (state)
            ST_RUN: begin
                if (press_mode) begin
                    state_next   = ST_SET_HOUR;
                    hours_next   = core.cur_hours;
                    minutes_next = core.cur_minutes;
                end
            end
            ST_SET_HOUR: begin
                if (press_mode)
                    state_next = ST_SET_MIN;
                else if (step_en)
                    hours_next = 5'(wrap_step({1'b0, hours_q}, HOURS_MAX, press_inc));
            end
            ST_SET_MIN: begin
                if (press_mode)
                    state_next = ST_COMMIT;
                else if (step_en)
                    minutes_next = wrap_step(minutes_q, MINUTES_MAX, press_inc);
            end
            default: state_next = ST_RUN;
        endcase
        // Idle seconds accumulate only while editing with no button activity.
        if (in_set && !any_press) begin
            idle_next = idle_count;
            if (tick_1hz) begin
                if (idle_count == TIMEOUT_LAST) begin
                    state_next = ST_RUN;
                    idle_next  = '0;
                end else begin
                    idle_next = idle_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        core.setting = in_set;
        core.load    = (state == ST_COMMIT);
        core.field   = FIELD_NONE;
        if (state == ST_SET_HOUR)
            core.field = FIELD_HOURS;
        else if (state == ST_SET_MIN)
            core.field = FIELD_MINUTES;
    end

    assign core.set_hours   = hours_q;
    assign core.set_minutes = minutes_q;
    assign core.set_seconds = '0;

endmodule

// File: tb/tb_clock_time_setter.sv
// tb/tb_clock_time_setter.sv - vector table, corner sequences and random ops against an event-level model
module tb_clock_time_setter;

    localparam int OP_MODE = 0, OP_INC = 1, OP_DEC = 2, OP_BOTH = 3, OP_MODE_INC = 4,
                   OP_TICK = 5, OP_GLITCH = 6, OP_MODE_DEC = 7;

    typedef struct {
        int op; int reps; int ch; int cm;
        int s; int f; int h; int m; int loads; int lh; int lm;
    } vec_t;

    logic clk = 1'b0;
    logic reset, bm, bi, bd, tick;
    always #5 clk = ~clk;

    clock_time_setter_if core_bus();

    clock_time_setter #(.DEBOUNCE_CYCLES(4), .TIMEOUT_S(3)) dut (
        .clkin(clk), .reset(reset), .btn_mode_raw(bm), .btn_inc_raw(bi),
        .btn_dec_raw(bd), .tick_1hz(tick), .core(core_bus));

    int total = 0, bad = 0;
    int load_cycles = 0, load_h = -1, load_m = -1, load_s = -1, load_bad = 0;
    int m_state = 0, m_h = 0, m_m = 0, m_idle = 0, m_loads = 0, m_lh = -1, m_lm = -1;
    vec_t vecs[$];

    always @(negedge clk) begin
        if (core_bus.load === 1'b1) begin
            load_cycles++;
            load_h = core_bus.set_hours;
            load_m = core_bus.set_minutes;
            load_s = core_bus.set_seconds;
            if (core_bus.setting !== 1'b0) load_bad++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_press(input bit m, input bit i, input bit d);
        m_idle = 0;
        case (m_state)
            0: if (m) begin m_state = 1; m_h = core_bus.cur_hours; m_m = core_bus.cur_minutes; end
            1: if (m) m_state = 2;
               else if (i != d) m_h = (m_h + (i ? 1 : 23)) % 24;
            default: if (m) begin m_state = 0; m_loads++; m_lh = m_h; m_lm = m_m; end
               else if (i != d) m_m = (m_m + (i ? 1 : 59)) % 60;
        endcase
    endfunction

    function automatic void model_tick();
        if (m_state != 0) begin
            m_idle++;
            if (m_idle >= 3) begin m_state = 0; m_idle = 0; end
        end
    endfunction

    task automatic do_buttons(input bit m, input bit i, input bit d, input int hold);
        @(negedge clk);
        bm = m; bi = i; bd = d;
        repeat (hold) @(negedge clk);
        bm = 1'b0; bi = 1'b0; bd = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic apply_op(input int op);
        case (op)
            OP_MODE:     begin do_buttons(1, 0, 0, 8); model_press(1, 0, 0); end
            OP_INC:      begin do_buttons(0, 1, 0, 8); model_press(0, 1, 0); end
            OP_DEC:      begin do_buttons(0, 0, 1, 8); model_press(0, 0, 1); end
            OP_BOTH:     begin do_buttons(0, 1, 1, 8); model_press(0, 1, 1); end
            OP_MODE_INC: begin do_buttons(1, 1, 0, 8); model_press(1, 1, 0); end
            OP_MODE_DEC: begin do_buttons(1, 0, 1, 8); model_press(1, 0, 1); end
            OP_GLITCH:   do_buttons(0, 1, 0, 3);
            default: begin
                @(negedge clk); tick = 1'b1;
                @(negedge clk); tick = 1'b0;
                repeat (2) @(negedge clk);
                model_tick();
            end
        endcase
    endtask

    task automatic chk_all(input string tag, input int s, input int f, input int h, input int m,
                           input int loads);
        chk({tag, " setting"}, core_bus.setting, s);
        chk({tag, " field"}, core_bus.field, f);
        chk({tag, " set_hours"}, core_bus.set_hours, h);
        chk({tag, " set_minutes"}, core_bus.set_minutes, m);
        chk({tag, " load_count"}, load_cycles, loads);
    endtask

    initial begin
        reset = 1'b1; bm = 1'b0; bi = 1'b0; bd = 1'b0; tick = 1'b0;
        core_bus.cur_hours = 5'd13; core_bus.cur_minutes = 6'd45;
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0);
        chk("reset load", core_bus.load, 0);
        chk("reset set_seconds", core_bus.set_seconds, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        vecs.push_back('{OP_INC,      1, 13, 45, 0, 0,  0,  0, 0, -1, -1});
        vecs.push_back('{OP_MODE,     1, 13, 45, 1, 1, 13, 45, 0, -1, -1});
        vecs.push_back('{OP_INC,     11, 13, 45, 1, 1,  0, 45, 0, -1, -1});
        vecs.push_back('{OP_GLITCH,   1, 13, 45, 1, 1,  0, 45, 0, -1, -1});
        vecs.push_back('{OP_MODE,     1, 13, 45, 1, 2,  0, 45, 0, -1, -1});
        vecs.push_back('{OP_DEC,      1, 13, 45, 1, 2,  0, 44, 0, -1, -1});
        vecs.push_back('{OP_BOTH,     1, 13, 45, 1, 2,  0, 44, 0, -1, -1});
        vecs.push_back('{OP_MODE,     1, 13, 45, 0, 0,  0, 44, 1,  0, 44});
        vecs.push_back('{OP_MODE_INC, 1,  0,  0, 1, 1,  0,  0, 1,  0, 44});
        vecs.push_back('{OP_DEC,      1,  0,  0, 1, 1, 23,  0, 1,  0, 44});
        vecs.push_back('{OP_INC,      1,  0,  0, 1, 1,  0,  0, 1,  0, 44});
        vecs.push_back('{OP_MODE,     1,  0,  0, 1, 2,  0,  0, 1,  0, 44});
        vecs.push_back('{OP_DEC,      1,  0,  0, 1, 2,  0, 59, 1,  0, 44});
        vecs.push_back('{OP_INC,      1,  0,  0, 1, 2,  0,  0, 1,  0, 44});
        vecs.push_back('{OP_DEC,      1,  0,  0, 1, 2,  0, 59, 1,  0, 44});
        vecs.push_back('{OP_MODE,     1,  0,  0, 0, 0,  0, 59, 2,  0, 59});

        foreach (vecs[k]) begin
            core_bus.cur_hours = 5'(vecs[k].ch);
            core_bus.cur_minutes = 6'(vecs[k].cm);
            for (int r = 0; r < vecs[k].reps; r++) apply_op(vecs[k].op);
            chk_all($sformatf("vec%0d", k), vecs[k].s, vecs[k].f, vecs[k].h, vecs[k].m, vecs[k].loads);
            if (vecs[k].loads > 0) begin
                chk($sformatf("vec%0d load_h", k), load_h, vecs[k].lh);
                chk($sformatf("vec%0d load_m", k), load_m, vecs[k].lm);
                chk($sformatf("vec%0d load_s", k), load_s, 0);
            end
        end

        // Timeout, then timeout with a press that restarts the count.
        core_bus.cur_hours = 5'd7; core_bus.cur_minutes = 6'd30;
        apply_op(OP_MODE);
        apply_op(OP_TICK); apply_op(OP_TICK);
        chk_all("to two ticks", 1, 1, 7, 30, 2);
        apply_op(OP_TICK);
        chk_all("to expired", 0, 0, 7, 30, 2);
        apply_op(OP_MODE);
        apply_op(OP_TICK); apply_op(OP_TICK);
        apply_op(OP_INC);
        apply_op(OP_TICK); apply_op(OP_TICK);
        chk_all("to restarted", 1, 1, 8, 30, 2);
        apply_op(OP_TICK);
        chk_all("to restart expired", 0, 0, 8, 30, 2);
        apply_op(OP_TICK);
        chk_all("tick in run", 0, 0, 8, 30, 2);

        // Reset in the middle of an edit.
        apply_op(OP_MODE); apply_op(OP_MODE); apply_op(OP_INC);
        chk_all("pre-reset", 1, 2, 7, 31, 2);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_all("mid-edit reset", 0, 0, 0, 0, 2);
        chk("mid-edit reset load", core_bus.load, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("after reset load_count", load_cycles, 2);

        m_state = 0; m_h = 0; m_m = 0; m_idle = 0; m_loads = load_cycles;
        for (int n = 0; n < 90; n++) begin
            int sel;
            core_bus.cur_hours = 5'($urandom_range(0, 23));
            core_bus.cur_minutes = 6'($urandom_range(0, 59));
            sel = $urandom_range(0, 11);
            apply_op(sel < 3 ? OP_MODE : (sel < 8 ? sel - 2 : (sel < 10 ? OP_TICK : OP_MODE_DEC)));
            chk_all($sformatf("rand%0d", n), (m_state != 0) ? 1 : 0, m_state, m_h, m_m, m_loads);
        end
        if (m_loads > 2) begin
            chk("rand load_h", load_h, m_lh);
            chk("rand load_m", load_m, m_lm);
        end
        chk("load while setting", load_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
